// File: rtl/serial_output_mc.sv
// Multi-channel serializer: captures one word per channel, optionally Gray-codes it,
// and shifts the low in_len bits out on every channel in lock-step, then idles GAP_CYC cycles.
module serial_output_mc #(
  parameter int unsigned NUM_CH    = 8,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned GAP_CYC   = 1,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          GRAY_EN   = 1'b1
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_CH*DATA_W-1:0]      in_data,
  input  logic [NUM_CH-1:0]             in_vld_mask,
  input  logic [$clog2(DATA_W+1)-1:0]   in_len,
  output logic [NUM_CH-1:0]             data_out,
  output logic [NUM_CH-1:0]             data_vld,
  output logic                          frame_done,
  output logic                          len_err,
  output logic                          busy
);
  localparam int unsigned LW = $clog2(DATA_W + 1);
  localparam int unsigned GW = 4;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            state;
  logic [LW-1:0]     cnt_q;
  logic [GW-1:0]     gap_q;
  logic [DATA_W-1:0] sh_q      [NUM_CH];
  logic [DATA_W-1:0] sh_next   [NUM_CH];
  logic [DATA_W-1:0] gray_w    [NUM_CH];
  logic [DATA_W-1:0] field_w   [NUM_CH];
  logic [DATA_W-1:0] load_rest [NUM_CH];
  logic [NUM_CH-1:0] first_bit;
  logic [NUM_CH-1:0] next_bit;
  logic [LW-1:0]     shamt;
  logic              len_ok;
  logic              accept;

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign len_ok   = (in_len != '0) && (in_len <= LW'(DATA_W));
  assign shamt    = LW'(DATA_W) - in_len;

  // Field alignment: MSB-first parks bit in_len-1 at the top of the shifter, LSB-first masks the field.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      gray_w[i] = GRAY_EN ? (in_data[i*DATA_W +: DATA_W] ^ (in_data[i*DATA_W +: DATA_W] >> 1))
                          : in_data[i*DATA_W +: DATA_W];
      if (MSB_FIRST) begin
        field_w[i]   = gray_w[i] << shamt;
        first_bit[i] = field_w[i][DATA_W-1];
        load_rest[i] = field_w[i] << 1;
        next_bit[i]  = sh_q[i][DATA_W-1];
        sh_next[i]   = sh_q[i] << 1;
      end else begin
        field_w[i]   = gray_w[i] & (ONES >> shamt);
        first_bit[i] = field_w[i][0];
        load_rest[i] = field_w[i] >> 1;
        next_bit[i]  = sh_q[i][0];
        sh_next[i]   = sh_q[i] >> 1;
      end
    end
  end

  // cnt_q counts bits still to present after the one currently on data_out.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      cnt_q      <= '0;
      gap_q      <= '0;
      sh_q       <= '{default: '0};
      data_out   <= '0;
      data_vld   <= '0;
      frame_done <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      len_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (len_ok) begin
              state    <= SHIFT;
              cnt_q    <= in_len - LW'(1);
              sh_q     <= load_rest;
              data_out <= first_bit & in_vld_mask;
              data_vld <= in_vld_mask;
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (cnt_q == '0) begin
            data_out   <= '0;
            data_vld   <= '0;
            frame_done <= 1'b1;
            if (GAP_CYC == 0) begin
              state <= IDLE;
            end else begin
              state <= GAP;
              gap_q <= GAP_LOAD;
            end
          end else begin
            cnt_q    <= cnt_q - LW'(1);
            sh_q     <= sh_next;
            // data_vld still holds the latched channel mask here
            data_out <= next_bit & data_vld;
          end
        end
        GAP: begin
          if (gap_q == '0) state <= IDLE;
          else             gap_q <= gap_q - GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_output_mc.sv
// Bench for serial_output_mc: four instances (default, LSB-first, no-Gray, zero-gap) share one
// stimulus stream; a frame-level model predicts every output each cycle, plus literal spot checks.
module tb_serial_output_mc;
  localparam int unsigned NCH = 8;
  localparam int unsigned DW  = 16;
  localparam int unsigned NI  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst;
  logic                        in_valid;
  logic [NCH*DW-1:0]           in_data;
  logic [NCH-1:0]              in_vld_mask;
  logic [$clog2(DW+1)-1:0]     in_len;
  logic                        in_ready [NI];
  logic [NCH-1:0]              dout     [NI];
  logic [NCH-1:0]              dvld     [NI];
  logic                        fdone    [NI];
  logic                        lerr     [NI];
  logic                        busy     [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    serial_output_mc #(
      .NUM_CH(NCH), .DATA_W(DW), .GAP_CYC((g == 3) ? 0 : 1),
      .MSB_FIRST(g != 1), .GRAY_EN(g != 2)
    ) u_dut (
      .clk_in(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[g]),
      .in_data(in_data), .in_vld_mask(in_vld_mask), .in_len(in_len),
      .data_out(dout[g]), .data_vld(dvld[g]), .frame_done(fdone[g]),
      .len_err(lerr[g]), .busy(busy[g])
    );
  end

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gap_of(int i);  return (i == 3) ? 0 : 1; endfunction
  function automatic bit msb_of(int i);  return i != 1;           endfunction
  function automatic bit gray_of(int i); return i != 2;           endfunction

  // Model: per instance, the last accepted frame and how many cycles have passed since acceptance.
  bit          f_act   [NI];
  bit          f_legal [NI];
  int          f_k     [NI];
  int          f_len   [NI];
  logic [7:0]  f_mask  [NI];
  logic [15:0] f_g     [NI][NCH];

  function automatic bit exp_busy(int i);
    return f_act[i] && f_legal[i] && (f_k[i] <= f_len[i] + gap_of(i));
  endfunction

  function automatic bit in_bits(int i);
    return f_act[i] && f_legal[i] && (f_k[i] >= 1) && (f_k[i] <= f_len[i]);
  endfunction

  function automatic logic [7:0] exp_dout(int i);
    logic [7:0] r;
    int idx;
    r = '0;
    if (in_bits(i)) begin
      idx = msb_of(i) ? (f_len[i] - f_k[i]) : (f_k[i] - 1);
      for (int c = 0; c < NCH; c++) r[c] = f_mask[i][c] & f_g[i][c][idx];
    end
    return r;
  endfunction

  function automatic bit any_busy();
    bit b;
    b = 1'b0;
    for (int i = 0; i < NI; i++) b = b | exp_busy(i);
    return b;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        f_act[i] <= 1'b0;
      end else if (in_valid && !exp_busy(i)) begin
        f_act[i]   <= 1'b1;
        f_k[i]     <= 1;
        f_len[i]   <= int'(in_len);
        f_legal[i] <= (in_len >= 1) && (in_len <= DW);
        f_mask[i]  <= in_vld_mask;
        for (int c = 0; c < NCH; c++)
          f_g[i][c] <= gray_of(i) ? (in_data[c*DW +: DW] ^ (in_data[c*DW +: DW] >> 1))
                                  : in_data[c*DW +: DW];
      end else if (f_act[i]) begin
        f_k[i] <= f_k[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("data_out[%0d]", i), 32'(dout[i]), 32'(exp_dout(i)));
        chk($sformatf("data_vld[%0d]", i), 32'(dvld[i]), in_bits(i) ? 32'(f_mask[i]) : 32'd0);
        chk($sformatf("frame_done[%0d]", i), 32'(fdone[i]),
            32'(f_act[i] && f_legal[i] && (f_k[i] == f_len[i] + 1)));
        chk($sformatf("len_err[%0d]", i), 32'(lerr[i]), 32'(f_act[i] && !f_legal[i] && (f_k[i] == 1)));
        chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(exp_busy(i)));
        chk($sformatf("in_ready[%0d]", i), 32'(in_ready[i]), 32'(!rst && !exp_busy(i)));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (any_busy() && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_bound", 32'(n < 100), 32'd1);
  endtask

  logic [15:0] sh16;
  logic [3:0]  b4 [NI];
  int          low, ec, nruns, run;
  logic [7:0]  vor;
  bit          rdy_ok;
  bit          s [2][60];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_vld_mask = '0; in_len = '0;
    cyc();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready[0]), 32'd0);
    chk("rst_outputs", 32'({dout[0], dvld[0], fdone[0], lerr[0], busy[0]}), 32'd0);
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready[0]), 32'd1);

    // Gray, MSB first, full length; inputs are scrambled during the frame
    cyc();
    in_data = '0; in_data[15:0] = 16'h0005; in_vld_mask = 8'h01; in_len = 5'd16; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0; in_data = {8{16'hBEEF}}; in_vld_mask = 8'hFF; in_len = 5'd3;
    sh16 = '0; low = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k <= 16) sh16 = {sh16[14:0], dout[0][0]};
      if (k == 17) chk("gray_frame_done", 32'(fdone[0]), 32'd1);
      if (!in_ready[0]) low++;
    end
    chk("gray_bits", 32'(sh16), 32'h0007);
    chk("gray_ready_low", 32'(low), 32'd17);

    // Short length on channel 3 across bit-order and Gray variants
    wait_idle();
    in_data = '0; in_data[3*DW +: DW] = 16'h000C; in_vld_mask = 8'h08; in_len = 5'd4; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < NI; i++) b4[i] = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) b4[i] = {b4[i][2:0], dout[i][3]};
    end
    chk("short_msb", 32'(b4[0]), 32'h0000000A);
    chk("short_lsb", 32'(b4[1]), 32'h00000005);
    chk("short_nogray", 32'(b4[2]), 32'h0000000C);

    // Illegal lengths 0 and 17
    for (int t = 0; t < 2; t++) begin
      wait_idle();
      in_data = {4{32'h1234ABCD}}; in_vld_mask = 8'hFF; in_len = (t == 0) ? 5'd0 : 5'd17;
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      ec = 0; vor = '0; rdy_ok = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        ec += int'(lerr[0]);
        vor |= dvld[0];
        if (!in_ready[0]) rdy_ok = 1'b0;
      end
      chk($sformatf("len_err_count_%0d", t), 32'(ec), 32'd1);
      chk($sformatf("len_err_vld_%0d", t), 32'(vor), 32'd0);
      chk($sformatf("len_err_ready_%0d", t), 32'(rdy_ok), 32'd1);
    end

    // Reset during bit 5 of a 16-bit frame
    wait_idle();
    in_data = {$urandom, $urandom, $urandom, $urandom}; in_vld_mask = 8'hFF; in_len = 5'd16;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_vld", 32'(dvld[0]), 32'd0);
    chk("abort_ready", 32'(in_ready[0]), 32'd1);
    ec = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ec += int'(fdone[0]);
    end
    chk("abort_no_done", 32'(ec), 32'd0);

    // Back-to-back frames with in_valid held high
    wait_idle();
    in_data = {$urandom, $urandom, $urandom, $urandom}; in_vld_mask = 8'hFF; in_len = 5'd8;
    in_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      s[0][t] = (dvld[0] == 8'hFF);
      s[1][t] = (dvld[3] == 8'hFF);
    end
    in_valid = 1'b0;
    for (int m = 0; m < 2; m++) begin
      nruns = 0; run = 1;
      for (int t = 1; t < 60; t++) begin
        if (s[m][t] == s[m][t-1]) begin
          run++;
        end else begin
          if (nruns > 0)
            chk($sformatf("b2b_run_m%0d_%s", m, s[m][t-1] ? "high" : "low"), 32'(run),
                s[m][t-1] ? 32'd8 : ((m == 0) ? 32'd2 : 32'd1));
          nruns++;
          run = 1;
        end
      end
      chk($sformatf("b2b_runs_m%0d", m), 32'(nruns >= 6), 32'd1);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/serial_output_mc.md
SERIAL_OUTPUT_MC -- requirements
Module: serial_output_mc

Interface
REQ-001 Parameter NUM_CH, default 8, SHALL set the number of serial output channels (1..32).
REQ-002 Parameter DATA_W, default 16, SHALL set the per-channel word width in bits (2..32).
REQ-003 Parameter GAP_CYC, default 1, SHALL set the number of idle cycles forced between frames (0..15).
REQ-004 Parameter MSB_FIRST, default 1, SHALL select the bit order: 1 = MSB first, 0 = LSB first.
REQ-005 Parameter GRAY_EN, default 1, SHALL enable binary-to-Gray conversion: 1 = convert, 0 = pass-through.
REQ-006 clk_in  input  1  SHALL be the single clock; all logic is rising-edge, and the block has one clock and no other clock domain.
REQ-007 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-008 in_valid  input  1  SHALL indicate that a frame is offered.
REQ-009 in_ready  output  1  SHALL indicate that the block accepts a frame this cycle.
REQ-010 in_data  input  NUM_CH*DATA_W  SHALL carry the channel words; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-011 in_vld_mask  input  NUM_CH  SHALL carry the per-channel enable; bit i controls channel i.
REQ-012 in_len  input  $clog2(DATA_W+1)  SHALL give the number of bits per channel to send; legal values are 1..DATA_W.
REQ-013 data_out  output  NUM_CH  SHALL carry the serial data, one bit per channel.
REQ-014 data_vld  output  NUM_CH  SHALL carry the per-channel serial valid.
REQ-015 frame_done  output  1  SHALL pulse for one cycle when a frame completes.
REQ-016 len_err  output  1  SHALL pulse for one cycle when a frame with an illegal length is rejected.
REQ-017 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, SHIFT and GAP; all outputs except in_ready and busy SHALL be registered.
REQ-019 in_ready SHALL be high only in IDLE and not in reset; a frame is accepted on a clock edge where in_valid && in_ready.
REQ-020 On acceptance with a legal in_len, the following SHALL occur:
- each channel word is captured as g = d ^ (d >> 1) when GRAY_EN=1, else g = d;
- the active field is g[in_len-1:0];
- in_vld_mask and in_len are latched;
- the state moves to SHIFT;
- on the same edge, data_out is loaded with the first bit and data_vld with the latched mask.
REQ-021 Bit order SHALL be g[in_len-1] down to g[0] when MSB_FIRST=1, and g[0] up to g[in_len-1] when MSB_FIRST=0.
REQ-022 data_vld[i] SHALL be high for exactly in_len consecutive cycles, starting the cycle after acceptance, for every masked-in channel.
REQ-023 Channels with a mask bit of 0 SHALL hold data_out[i]=0 and data_vld[i]=0 for the whole frame.
REQ-024 A frame with in_vld_mask=0 and a legal length SHALL run the full timing: no data_vld, frame_done still pulses.
REQ-025 On the edge after the last bit, the block SHALL:
- clear data_out and data_vld to 0;
- pulse frame_done for one cycle;
- enter GAP, or enter IDLE directly when GAP_CYC=0.
REQ-026 GAP SHALL last exactly GAP_CYC cycles, then return to IDLE; the accept-to-accept period is therefore in_len+GAP_CYC+1 cycles.
REQ-027 An illegal in_len (0 or >DATA_W) SHALL be handled as follows:
- the frame is still accepted (handshake completes);
- len_err pulses for one cycle on the next edge;
- no data_vld is raised and frame_done does not pulse;
- the state stays IDLE.
REQ-028 in_data, in_vld_mask and in_len changes while not in IDLE SHALL have no effect on the frame in progress.
REQ-029 The internal bit counter SHALL be $clog2(DATA_W+1) bits wide and SHALL never wrap within a frame.

Reset
REQ-030 While rst is high at a clock edge, the block SHALL hold:
- state IDLE;
- data_out=0, data_vld=0, frame_done=0, len_err=0, busy=0;
- in_ready=0.
REQ-031 rst asserted mid-frame SHALL abort the frame:
- data_vld goes 0 on the reset edge;
- no frame_done pulse is produced;
- in_ready=1 on the first cycle after rst deasserts.

Verification (NUM_CH=8, DATA_W=16, GAP_CYC=1 unless stated)
REQ-032 Reset check: hold rst for 3 cycles, then release -> all outputs read 0 during reset, and in_ready=1 on the first cycle after release.
REQ-033 Gray, MSB first:
- stimulus: ch0 = 16'h0005, mask 8'h01, in_len 16;
- response: data_out[0] = 0000000000000111 over 16 cycles;
- frame_done pulses on cycle 17;
- in_ready is low for 17 cycles after acceptance, counting the gap cycle.
REQ-034 Short length, both bit orders:
- stimulus: ch3 = 16'h000C, mask 8'h08, in_len 4;
- MSB_FIRST=1 -> 1,0,1,0;
- MSB_FIRST=0 -> 0,1,0,1;
- GRAY_EN=0 with MSB_FIRST=1 -> 1,1,0,0.
REQ-035 Length error: in_len=0, then in_len=17 -> len_err pulses once per frame, data_vld stays 8'h00, and in_ready stays 1.
REQ-036 Mid-frame reset: rst asserted during bit 5 of a 16-bit frame -> data_vld=0 on the next cycle, no frame_done, in_ready=1 after release.
REQ-037 Back-to-back frames:
- stimulus: in_valid held high, mask 8'hFF, in_len 8;
- response: data_vld is high for 8 cycles, then low for exactly 2 cycles, repeating;
- with GAP_CYC=0, data_vld is low for exactly 1 cycle between frames.
